pc_stack: RTL and testbench

- Parametrised program counter that succeeds the fixed 5-bit PC.
- Adds configurable width, a reset vector, and sequential increment.
- Adds absolute jump, PC-relative conditional branch, and a hardware return-address stack for CALL/RET.
- Sits between the control unit, which issues pc_op, and instruction memory, which is addressed by pc_out.

---
 rtl/pc_stack.sv | 120 ++++++++++++
 tb/tb_pc_stack.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// Parametrised program counter with jump, relative branch and a
// hardware return-address stack for CALL/RET.
module pc_stack #(
  parameter int PC_WIDTH = 5,
  parameter int STACK_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic [2:0]                         pc_op,
  input  logic                               cond,
  input  logic [PC_WIDTH-1:0]                target,
  input  logic [PC_WIDTH-1:0]                offset,
  output logic [PC_WIDTH-1:0]                pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_count,
  output logic                               stk_overflow,
  output logic                               stk_underflow
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] top;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [SPW-1:0]      sp_nxt;
  logic                ovf_nxt;
  logic                unf_nxt;
  logic                push;
  logic                full;
  logic                empty;
  logic                op_next;
  logic                op_jump;
  logic                op_br;
  logic                op_call;
  logic                op_ret;
  logic                op_hold;

  assign pc_inc = pc_out + PC_ONE;
  assign full   = (sp_count == SP_FULL);
  assign empty  = (sp_count == '0);

  assign op_next = (pc_op == 3'b000);
  assign op_jump = (pc_op == 3'b001);
  assign op_br   = (pc_op == 3'b010);
  assign op_call = (pc_op == 3'b011);
  assign op_ret  = (pc_op == 3'b100);
  // 101 is HOLD; 110/111 are reserved and alias to it
  assign op_hold = pc_op[2] & (pc_op[1] | pc_op[0]);

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (SPW'(i) == sp_count - SP_ONE) top = stack[i];
    end
  end

  always_comb begin
    pc_nxt  = pc_out;
    sp_nxt  = sp_count;
    ovf_nxt = stk_overflow;
    unf_nxt = stk_underflow;
    push    = 1'b0;
    if (!stall) begin
      unique case (1'b1)
        op_next: pc_nxt = pc_inc;
        op_jump: pc_nxt = target;
        op_br:   pc_nxt = cond ? pc_out + offset : pc_inc;
        op_call: begin
          pc_nxt = target;
          if (full) begin
            ovf_nxt = 1'b1;
          end else begin
            push   = 1'b1;
            sp_nxt = sp_count + SP_ONE;
          end
        end
        op_ret: begin
          if (empty) begin
            pc_nxt  = pc_inc;
            unf_nxt = 1'b1;
          end else begin
            pc_nxt = top;
            sp_nxt = sp_count - SP_ONE;
          end
        end
        op_hold: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out        <= RESET_VECTOR;
      sp_count      <= '0;
      stk_overflow  <= 1'b0;
      stk_underflow <= 1'b0;
    end else begin
      pc_out        <= pc_nxt;
      sp_count      <= sp_nxt;
      stk_overflow  <= ovf_nxt;
      stk_underflow <= unf_nxt;
    end
  end

  // Entries are don't-care after reset, so no reset on the array
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (SPW'(i) == sp_count) stack[i] <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Directed-vector bench for pc_stack.
// RESET_VECTOR=3, 5-bit PC, 4-entry stack.
module tb_pc_stack;

  localparam logic [2:0] NXT = 3'b000;
  localparam logic [2:0] JMP = 3'b001;
  localparam logic [2:0] BRA = 3'b010;
  localparam logic [2:0] CAL = 3'b011;
  localparam logic [2:0] RET = 3'b100;
  localparam logic [2:0] HLD = 3'b101;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] pc_op = HLD;
  logic       cond = 1'b0;
  logic [4:0] target = '0;
  logic [4:0] offset = '0;
  logic [4:0] pc_out;
  logic [2:0] sp_count;
  logic       stk_overflow;
  logic       stk_underflow;

  int n_tests = 0;
  int n_fail = 0;

  pc_stack #(
    .PC_WIDTH(5),
    .STACK_DEPTH(4),
    .RESET_VECTOR(5'd3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .pc_op(pc_op),
    .cond(cond),
    .target(target),
    .offset(offset),
    .pc_out(pc_out),
    .sp_count(sp_count),
    .stk_overflow(stk_overflow),
    .stk_underflow(stk_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [2:0] op,
                      input logic [4:0] tgt,
                      input logic [4:0] off,
                      input logic c,
                      input logic st);
    pc_op  = op;
    target = tgt;
    offset = off;
    cond   = c;
    stall  = st;
    @(posedge clk);
    #1;
  endtask

  task automatic st_chk(input string tag,
                        input logic [4:0] pc,
                        input logic [2:0] sp,
                        input logic ovf,
                        input logic unf);
    chk({tag, ".pc"}, 32'(pc_out), 32'(pc));
    chk({tag, ".sp"}, 32'(sp_count), 32'(sp));
    chk({tag, ".ovf"}, 32'(stk_overflow), 32'(ovf));
    chk({tag, ".unf"}, 32'(stk_underflow), 32'(unf));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    st_chk("reset", 5'd3, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_hold", 32'(pc_out), 32'd3);

    step(NXT, 0, 0, 0, 0); chk("next1", 32'(pc_out), 32'd4);
    step(NXT, 0, 0, 0, 0); chk("next2", 32'(pc_out), 32'd5);
    step(NXT, 0, 0, 0, 0); chk("next3", 32'(pc_out), 32'd6);
    step(NXT, 0, 0, 0, 0);
    st_chk("next4", 5'd7, 3'd0, 1'b0, 1'b0);

    step(JMP, 5'd31, 0, 0, 0); chk("jmp31", 32'(pc_out), 32'd31);
    step(NXT, 0, 0, 0, 0); chk("wrap", 32'(pc_out), 32'd0);
    step(JMP, 5'd10, 0, 0, 0); chk("jmp10", 32'(pc_out), 32'd10);
    step(BRA, 0, 5'b11110, 1, 0); chk("br_taken", 32'(pc_out), 32'd8);
    step(BRA, 0, 5'b11110, 0, 0); chk("br_not", 32'(pc_out), 32'd9);
    step(BRA, 0, 5'd25, 1, 0); chk("br_wrap", 32'(pc_out), 32'd2);

    step(CAL, 5'd20, 0, 0, 0); st_chk("call20", 5'd20, 3'd1, 0, 0);
    step(CAL, 5'd25, 0, 0, 0); st_chk("call25", 5'd25, 3'd2, 0, 0);
    step(RET, 0, 0, 0, 0); st_chk("ret1", 5'd21, 3'd1, 0, 0);
    step(RET, 0, 0, 0, 0); st_chk("ret2", 5'd3, 3'd0, 0, 0);

    // pc=3: pushes 4, 11, 12, 13 then overflow
    step(CAL, 5'd10, 0, 0, 0); chk("c1", 32'(pc_out), 32'd10);
    step(CAL, 5'd11, 0, 0, 0); chk("c2", 32'(pc_out), 32'd11);
    step(CAL, 5'd12, 0, 0, 0); chk("c3", 32'(pc_out), 32'd12);
    step(CAL, 5'd13, 0, 0, 0); st_chk("c4_full", 5'd13, 3'd4, 0, 0);
    step(CAL, 5'd14, 0, 0, 0); st_chk("c5_ovf", 5'd14, 3'd4, 1, 0);
    step(RET, 0, 0, 0, 0); st_chk("r1", 5'd13, 3'd3, 1, 0);
    step(RET, 0, 0, 0, 0); st_chk("r2", 5'd12, 3'd2, 1, 0);
    step(RET, 0, 0, 0, 0); st_chk("r3", 5'd11, 3'd1, 1, 0);
    step(RET, 0, 0, 0, 0); st_chk("r4", 5'd4, 3'd0, 1, 0);
    step(RET, 0, 0, 0, 0); st_chk("r5_unf", 5'd5, 3'd0, 1, 1);
    step(NXT, 0, 0, 0, 0); st_chk("sticky1", 5'd6, 3'd0, 1, 1);
    step(NXT, 0, 0, 0, 0); st_chk("sticky2", 5'd7, 3'd0, 1, 1);

    step(HLD, 5'd1, 0, 0, 0); chk("hold", 32'(pc_out), 32'd7);
    step(3'b110, 5'd1, 0, 0, 0); chk("rsv6", 32'(pc_out), 32'd7);
    step(3'b111, 5'd1, 0, 0, 0); chk("rsv7", 32'(pc_out), 32'd7);

    // CALL from pc=31 pushes wrapped 0
    step(JMP, 5'd31, 0, 0, 0);
    step(CAL, 5'd7, 0, 0, 0); st_chk("call_wrap", 5'd7, 3'd1, 1, 1);
    step(CAL, 5'd2, 0, 0, 1); st_chk("stall_call", 5'd7, 3'd1, 1, 1);
    step(RET, 0, 0, 0, 1); st_chk("stall_ret", 5'd7, 3'd1, 1, 1);
    step(JMP, 5'd9, 0, 0, 1); st_chk("stall_jmp", 5'd7, 3'd1, 1, 1);
    step(RET, 0, 0, 0, 0); st_chk("ret_wrap", 5'd0, 3'd0, 1, 1);

    step(JMP, 5'd1, 0, 0, 0);
    step(CAL, 5'd5, 0, 0, 0);
    step(CAL, 5'd14, 0, 0, 0); st_chk("pre_arst", 5'd14, 3'd2, 1, 1);
    pc_op = HLD;
    #3;
    reset = 1'b0;
    #1;
    st_chk("arst", 5'd3, 3'd0, 0, 0);
    #2;
    reset = 1'b1;
    step(RET, 0, 0, 0, 0); st_chk("post_ret", 5'd4, 3'd0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
